instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Front pipeline stage of the RV32 core; sits directly upstream of the decode stage and feeds its INSTRUCTION input.
- Owns the PC register and the instruction-memory read handshake.
- Holds the IF/ID pipeline register.
- Accepts hazard stalls and taken-branch/jump redirects resolved in EX.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (ADDI x0,x0,0) placed in IF/ID on flush/empty

Ports:
- CLK  input  1  core clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- PC_STALL  input  1  hazard stall: hold PC and IF/ID
- BRANCH_TAKEN  input  1  redirect pulse from EX (JAL/JALR/taken branch)
- BRANCH_TARGET  input  32  redirect address; bits [1:0] ignored (treated as 0)
- INSTR_MEM_READ  output  1  fetch request
- INSTR_MEM_ADDRESS  output  32  fetch address
- INSTR_MEM_READDATA  input  32  fetched word, valid in accept cycle
- INSTR_MEM_BUSYWAIT  input  1  memory not ready
- PR_INSTRUCTION  output  32  IF/ID instruction to decoder
- PR_PC  output  32  IF/ID PC of PR_INSTRUCTION
- PR_VALID  output  1  IF/ID holds a real instruction

Behaviour:
- Reset: one clock and one reset (RESET synchronous, active-high). On a RESET edge:
  - state=IDLE, PC=RESET_VECTOR, pending flag cleared, buffer cleared.
  - INSTR_MEM_READ=0, PR_INSTRUCTION=NOP_INSTR, PR_PC=0, PR_VALID=0.
  - Reset mid-transaction drops the request; the instruction memory shares RESET and aborts.
- Handshake:
  - Accept cycle = INSTR_MEM_READ=1 and INSTR_MEM_BUSYWAIT=0.
  - While BUSYWAIT=1, INSTR_MEM_ADDRESS stays stable and READ stays asserted.
  - INSTR_MEM_ADDRESS = PC, combinational.
- Latency: RESET falls → cycle 1 first request. On a zero-wait hit, PR_VALID=1 after the next edge. Steady state: 1 instruction/cycle.
- States:
  - IDLE: READ=0; next state REQ.
  - REQ: READ=1. Evaluate in priority order:
    1. Accept with BRANCH_TAKEN=1 → data discarded; PC<=BRANCH_TARGET; IF/ID<=NOP, valid 0; stay REQ.
    2. Accept with pending set (no BRANCH_TAKEN) → data discarded; PC<=pending target; clear pending; IF/ID<=NOP; stay REQ.
    3. No accept and BRANCH_TAKEN=1 → pending<=1, pending target<=BRANCH_TARGET (latest overwrites); IF/ID<=NOP; PC unchanged.
    4. Accept with PC_STALL=1 → buffer<=READDATA, buffer PC<=PC; PC<=PC+4; IF/ID held; go HELD.
    5. Accept otherwise → IF/ID<={READDATA, PC, valid 1}; PC<=PC+4.
    6. No accept, PC_STALL=1 → IF/ID held.
    7. No accept, PC_STALL=0 → IF/ID<=NOP, valid 0 (bubble).
  - HELD: READ=0. Evaluate in priority order:
    1. BRANCH_TAKEN=1 → buffer dropped; PC<=BRANCH_TARGET; IF/ID<=NOP; go REQ.
    2. PC_STALL=0 → IF/ID<={buffer, buffer PC, valid 1}; go REQ.
    3. Otherwise hold.
- BRANCH_TAKEN always overrides PC_STALL.
- A redirect that arrives in IDLE is applied to PC directly.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- PC changes only on accept, redirect, or reset.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs FETCH_COUNT[31:0] (instructions written into IF/ID with valid 1) and FETCH_WAIT_COUNT[31:0] (cycles with READ=1 and BUSYWAIT=1).
  - Both cleared on RESET and wrap at 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset release, memory BUSYWAIT=0, words W0..W3 at 0x0..0xC → ADDRESS 0,4,8,C on successive cycles; PR_PC 0,4,8 with PR_VALID=1 from the second cycle after release.
2. BUSYWAIT high 3 cycles on PC=0x8 → ADDRESS stays 0x8 and READ=1 for all 3 cycles; PR_VALID=0 bubbles for 3 cycles; FETCH_WAIT_COUNT=3 when the macro is defined.
3. BRANCH_TAKEN with BRANCH_TARGET=0x100 during BUSYWAIT on PC=0x10 → word at 0x10 discarded; next ADDRESS=0x100; PR_VALID=0 for the redirect cycle and the accept cycle.
4. PC_STALL=1 while the 0x14 fetch is accepted → state HELD, READ=0, IF/ID unchanged; PC_STALL drops → PR_PC=0x14 next edge, then fetch resumes at 0x18.
5. BRANCH_TAKEN and PC_STALL together in HELD with target 0x200 → buffer dropped; PR_INSTRUCTION=32'h0000_0013; next ADDRESS=0x200.
6. PC=0xFFFF_FFFC accepted, then RESET asserted mid BUSYWAIT → next PC 0x0 (wrap); after RESET, READ=0, PR_VALID=0, PC=RESET_VECTOR.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, instruction-memory read handshake,
// IF/ID pipeline register, hazard stall and EX-resolved redirect handling.
// Optional performance counters are compiled in with IF_PERF_CNT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | out of reset, no request yet; next cycle starts fetching
// REQ   | fetch request asserted at PC, waiting for/consuming the accept
// HELD  | accepted word parked in the buffer while decode is stalled
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PC_STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        INSTR_MEM_READ,
  output logic [31:0] INSTR_MEM_ADDRESS,
  input  logic [31:0] INSTR_MEM_READDATA,
  input  logic        INSTR_MEM_BUSYWAIT,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] FETCH_WAIT_COUNT,
`endif
  output logic [31:0] PR_INSTRUCTION,
  output logic [31:0] PR_PC,
  output logic        PR_VALID
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] pr_instr_q, pr_instr_d;
  logic [31:0] pr_pc_q, pr_pc_d;
  logic        pr_valid_q, pr_valid_d;

  logic        mem_read;
  logic        accept;
  logic [31:0] br_tgt;
  logic [31:0] pc_inc;

  // Handshake signals and redirect address (low two bits forced to zero)
  always_comb begin
    mem_read = (state_q == ST_REQ);
    accept   = mem_read & ~INSTR_MEM_BUSYWAIT;
    br_tgt   = BRANCH_TARGET & ~32'h0000_0003;
    pc_inc   = pc_q + 32'd4;
  end

  assign INSTR_MEM_READ    = mem_read;
  assign INSTR_MEM_ADDRESS = pc_q;
  assign PR_INSTRUCTION    = pr_instr_q;
  assign PR_PC             = pr_pc_q;
  assign PR_VALID          = pr_valid_q;

  // Next-state, PC, pending-redirect, buffer and IF/ID update
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    pr_instr_d  = pr_instr_q;
    pr_pc_d     = pr_pc_q;
    pr_valid_d  = pr_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (BRANCH_TAKEN) pc_d = br_tgt;
      end

      ST_REQ: begin
        if (accept && BRANCH_TAKEN) begin
          pc_d       = br_tgt;
          pend_d     = 1'b0;
          pr_instr_d = NOP_INSTR;
          pr_pc_d    = 32'd0;
          pr_valid_d = 1'b0;
        end else if (accept && pend_q) begin
          // word fetched from the stale path; jump to the remembered target
          pc_d       = pend_tgt_q;
          pend_d     = 1'b0;
          pr_instr_d = NOP_INSTR;
          pr_pc_d    = 32'd0;
          pr_valid_d = 1'b0;
        end else if (!accept && BRANCH_TAKEN) begin
          // memory still busy on the old address; finish it, then redirect
          pend_d     = 1'b1;
          pend_tgt_d = br_tgt;
          pr_instr_d = NOP_INSTR;
          pr_pc_d    = 32'd0;
          pr_valid_d = 1'b0;
        end else if (accept && PC_STALL) begin
          buf_instr_d = INSTR_MEM_READDATA;
          buf_pc_d    = pc_q;
          pc_d        = pc_inc;
          state_d     = ST_HELD;
        end else if (accept) begin
          pr_instr_d = INSTR_MEM_READDATA;
          pr_pc_d    = pc_q;
          pr_valid_d = 1'b1;
          pc_d       = pc_inc;
        end else if (!PC_STALL) begin
          pr_instr_d = NOP_INSTR;
          pr_pc_d    = 32'd0;
          pr_valid_d = 1'b0;
        end
      end

      ST_HELD: begin
        if (BRANCH_TAKEN) begin
          pc_d       = br_tgt;
          pend_d     = 1'b0;
          pr_instr_d = NOP_INSTR;
          pr_pc_d    = 32'd0;
          pr_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (!PC_STALL) begin
          pr_instr_d = buf_instr_q;
          pr_pc_d    = buf_pc_q;
          pr_valid_d = 1'b1;
          state_d    = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_VECTOR;
      pend_q      <= 1'b0;
      pend_tgt_q  <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      pr_instr_q  <= NOP_INSTR;
      pr_pc_q     <= 32'd0;
      pr_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      pr_instr_q  <= pr_instr_d;
      pr_pc_q     <= pr_pc_d;
      pr_valid_q  <= pr_valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        fetch_inc;

  // A fetch is counted when a real instruction lands in IF/ID
  always_comb begin
    fetch_inc = ((state_q == ST_REQ) && accept && !BRANCH_TAKEN && !pend_q && !PC_STALL) ||
                ((state_q == ST_HELD) && !BRANCH_TAKEN && !PC_STALL);
    fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_inc};
    wait_cnt_d  = wait_cnt_q + {31'd0, (mem_read & INSTR_MEM_BUSYWAIT)};
  end

  // Performance counters, free-running and wrapping
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_cnt_q <= 32'd0;
      wait_cnt_q  <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign FETCH_COUNT      = fetch_cnt_q;
  assign FETCH_WAIT_COUNT = wait_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small instruction memory
// model and a queue of expected IF/ID contents.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic [31:0] pr_instr;
  logic [31:0] pr_pc;
  logic        pr_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] fetch_wait_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
  } pr_exp_t;

  pr_exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, 16'h0000} ^ {a[15:0], a[31:16]} ^ 32'h0000_5A00;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  instruction_fetch_unit dut (
    .CLK                (clk),
    .RESET              (reset),
    .PC_STALL           (pc_stall),
    .BRANCH_TAKEN       (branch_taken),
    .BRANCH_TARGET      (branch_target),
    .INSTR_MEM_READ     (mem_read),
    .INSTR_MEM_ADDRESS  (mem_addr),
    .INSTR_MEM_READDATA (mem_rdata),
    .INSTR_MEM_BUSYWAIT (mem_busy),
`ifdef IF_PERF_CNT_EN
    .FETCH_COUNT        (fetch_count),
    .FETCH_WAIT_COUNT   (fetch_wait_count),
`endif
    .PR_INSTRUCTION     (pr_instr),
    .PR_PC              (pr_pc),
    .PR_VALID           (pr_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check this cycle's request, drive inputs, push the IF/ID content expected
  // after the edge, then pop and compare once the edge has happened.
  task automatic step(input logic exp_rd, input logic [31:0] exp_addr,
                      input logic busy, input logic stall, input logic br,
                      input logic [31:0] tgt, input logic exp_v,
                      input logic [31:0] exp_pc);
    pr_exp_t e;
    chk("mem_read", {31'd0, mem_read}, {31'd0, exp_rd});
    chk("mem_addr", mem_addr, exp_addr);
    mem_busy      = busy;
    pc_stall      = stall;
    branch_taken  = br;
    branch_target = tgt;
    e.v     = exp_v;
    e.pc    = exp_pc;
    e.instr = exp_v ? mem_word(exp_pc) : NOP;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    chk("pr_valid", {31'd0, pr_valid}, {31'd0, e.v});
    chk("pr_instr", pr_instr, e.instr);
    if (e.v) chk("pr_pc", pr_pc, e.pc);
  endtask

  initial begin
    reset         = 1'b1;
    pc_stall      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    mem_busy      = 1'b0;
    tick();
    tick();
    chk("rst_read", {31'd0, mem_read}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_instr", pr_instr, NOP);
    chk("rst_pc", pr_pc, 32'd0);
    chk("rst_valid", {31'd0, pr_valid}, 32'd0);

    // reset release: IDLE -> REQ
    reset = 1'b0;
    tick();
    chk("rel_valid", {31'd0, pr_valid}, 32'd0);

    // sequential fetch, then 3 wait cycles on 0x8
    step(1, 32'h0,   0, 0, 0, 0, 1, 32'h0);
    step(1, 32'h4,   0, 0, 0, 0, 1, 32'h4);
    step(1, 32'h8,   1, 0, 0, 0, 0, 0);
    step(1, 32'h8,   1, 0, 0, 0, 0, 0);
    step(1, 32'h8,   1, 0, 0, 0, 0, 0);
    step(1, 32'h8,   0, 0, 0, 0, 1, 32'h8);
    step(1, 32'hC,   0, 0, 0, 0, 1, 32'hC);
`ifdef IF_PERF_CNT_EN
    chk("fetch_wait_count", fetch_wait_count, 32'd3);
    chk("fetch_count", fetch_count, 32'd4);
`endif

    // redirect during busywait on 0x10
    step(1, 32'h10,  1, 0, 1, 32'h100, 0, 0);
    step(1, 32'h10,  0, 0, 0, 0,       0, 0);
    step(1, 32'h100, 0, 0, 0, 0,       1, 32'h100);
    // redirect on accept, low target bits ignored
    step(1, 32'h104, 0, 0, 1, 32'h17,  0, 0);

    // stall on accept of 0x14 -> HELD, then release
    step(1, 32'h14,  0, 1, 0, 0, 0, 0);
    step(0, 32'h18,  0, 1, 0, 0, 0, 0);
    step(0, 32'h18,  0, 0, 0, 0, 1, 32'h14);
    step(1, 32'h18,  0, 0, 0, 0, 1, 32'h18);

    // branch and stall together while HELD
    step(1, 32'h1C,  0, 1, 0, 0,       1, 32'h18);
    step(0, 32'h20,  0, 1, 1, 32'h200, 0, 0);
    step(1, 32'h200, 0, 0, 0, 0,       1, 32'h200);

    // PC wrap, then reset mid busywait
    step(1, 32'h204,      0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step(1, 32'hFFFF_FFFC, 0, 0, 0, 0,           1, 32'hFFFF_FFFC);
    step(1, 32'h0,        1, 0, 0, 0,            0, 0);
    reset    = 1'b1;
    mem_busy = 1'b1;
    tick();
    chk("rst2_read", {31'd0, mem_read}, 32'd0);
    chk("rst2_addr", mem_addr, 32'd0);
    chk("rst2_valid", {31'd0, pr_valid}, 32'd0);
    chk("rst2_instr", pr_instr, NOP);

    // redirect while IDLE goes straight to PC
    reset         = 1'b0;
    mem_busy      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h43;
    tick();
    step(1, 32'h40, 0, 0, 0, 0, 1, 32'h40);
    step(1, 32'h44, 0, 0, 0, 0, 1, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
